// File: rtl/sbmips_pkg.sv
// Shared constants for the sbmips pipeline stages.
// Register/instruction encodings referenced by more than one stage live here.
package sbmips_pkg;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] NOP_INST = 32'h00000000;
  localparam logic [5:0]  OP_LW    = 6'h23;
  localparam logic [5:0]  OP_SW    = 6'h2b;

endpackage

// File: rtl/inst_memory_if.sv
// Stage bus between execute and the memory/write-back stage.
// Master is the execute side; slave is inst_memory.
interface inst_memory_if;

  logic [29:0] pc_in;
  logic [31:0] inst_in;
  logic        load;
  logic        store;
  logic [4:0]  rd_in;
  logic [31:0] rd_val_in;
  logic [31:0] mem_dout;
  logic [4:0]  mem_rd;
  logic [31:0] mem_rd_val;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic [29:0] pc_out;
  logic [31:0] inst_out;

  modport master (
    output pc_in, inst_in, load, store, rd_in, rd_val_in, mem_dout,
    input  mem_rd, mem_rd_val, reg_we, reg_waddr, reg_wdata, pc_out, inst_out
  );

  modport slave (
    input  pc_in, inst_in, load, store, rd_in, rd_val_in, mem_dout,
    output mem_rd, mem_rd_val, reg_we, reg_waddr, reg_wdata, pc_out, inst_out
  );

endinterface

// File: rtl/inst_memory_event_counter.sv
// Free-running enabled event counter with synchronous reset.
// Wraps silently modulo 2^W.
module event_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (en)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/inst_memory.sv
// Memory/write-back stage: selects the load or ALU result, registers the
// register-file write, and forwards load data back to execute with no stall.
module inst_memory
  import sbmips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  inst_memory_if.slave     bus,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] store_cnt
);

  logic [31:0] res;
  logic [4:0]  dst;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [29:0] pc_q;
  logic [31:0] inst_q;

  // A store (including the illegal load+store case) never writes a register.
  always_comb begin
    res = bus.load ? bus.mem_dout : bus.rd_val_in;
    dst = bus.store ? REG_ZERO : bus.rd_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_addr <= REG_ZERO;
      wb_data <= '0;
      pc_q    <= '0;
      inst_q  <= NOP_INST;
    end else begin
      wb_addr <= dst;
      wb_data <= (dst == REG_ZERO) ? '0 : res;
      pc_q    <= bus.pc_in;
      inst_q  <= bus.inst_in;
    end
  end

  assign bus.reg_we    = (wb_addr != REG_ZERO);
  assign bus.reg_waddr = wb_addr;
  assign bus.reg_wdata = wb_data;
  assign bus.pc_out    = pc_q;
  assign bus.inst_out  = inst_q;

  // Only loads are forwarded from this stage; execute bypasses its own ALU result.
  always_comb begin
    bus.mem_rd     = wb_addr;
    bus.mem_rd_val = wb_data;
    if (bus.load && (bus.rd_in != REG_ZERO)) begin
      bus.mem_rd     = bus.rd_in;
      bus.mem_rd_val = bus.mem_dout;
    end
  end

  event_counter #(.W(CNT_W)) u_retired_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.inst_in != NOP_INST),
    .count (retired_cnt)
  );

  event_counter #(.W(CNT_W)) u_load_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.load),
    .count (load_cnt)
  );

  event_counter #(.W(CNT_W)) u_store_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.store),
    .count (store_cnt)
  );

endmodule

// File: doc/inst_memory.md
# inst_memory

Memory/write-back stage of the sbmips five-stage pipeline, sitting directly after the execute stage. Consumes execute's registered outputs (load/store/rd/rd_val) together with the synchronous data-RAM read port, and produces the register-file write for the retiring instruction. Feeds a forwarding pair (`mem_rd`/`mem_rd_val`) back to execute for load-use and two-back bypassing. Maintains retire/load/store event counters for bring-up.

## Interface
Parameters:
- `CNT_W`, default 32: width of each event counter.

Ports:
- `clk`  in  1: the single clock; all state updates on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `pc_in`  in  30: word PC of instruction in this stage (execute `pc_out`).
- `inst_in`  in  32: instruction word; `32'h00000000` = bubble.
- `load`  in  1: instruction is a load (lw).
- `store`  in  1: instruction is a store (sw).
- `rd_in`  in  5: destination register from execute.
- `rd_val_in`  in  32: ALU result / link value from execute.
- `mem_dout`  in  32: data-RAM read data, valid in the cycle after execute asserted `mem_en` with `mem_we=0`.
- `mem_rd`  out  5: forwarding destination to execute (0 = none).
- `mem_rd_val`  out  32: forwarding value to execute.
- `reg_we`  out  1: register-file write enable.
- `reg_waddr`  out  5: register-file write address.
- `reg_wdata`  out  32: register-file write data.
- `pc_out`  out  30: PC of retiring instruction.
- `inst_out`  out  32: retiring instruction word.
- `retired_cnt`, `load_cnt`, `store_cnt`  out  CNT_W each: event counters.

## Operation
- Result select (combinational): `res = load ? mem_dout : rd_val_in`; destination `dst = store ? 0 : rd_in`.
- Write-back register (WB), updated every clock: `wb_addr <= dst`, `wb_data <= (dst==0) ? 0 : res`, `pc_out <= pc_in`, `inst_out <= inst_in`.
- Outputs from WB: `reg_we = (wb_addr != 0)`, `reg_waddr = wb_addr`, `reg_wdata = wb_data`. Register 0 never written.
- Forwarding (combinational, priority): if `load && rd_in != 0` -> `mem_rd = rd_in`, `mem_rd_val = mem_dout`; else `mem_rd = wb_addr`, `mem_rd_val = wb_data`. Non-load results of the current stage are not forwarded here (execute's own last-result bypass covers them).
- Counters: `retired_cnt` +1 each cycle `inst_in != 0`; `load_cnt` +1 when `load`; `store_cnt` +1 when `store`. All wrap modulo 2^CNT_W silently.
- `load` and `store` simultaneously high is illegal; behaviour: treated as store (no register write, counted in both `load_cnt` and `store_cnt`).

## Timing
- Latency: one clock from stage inputs to `reg_we`/`reg_waddr`/`reg_wdata`/`pc_out`/`inst_out`.
- Forwarding outputs are zero-latency (same cycle as inputs / `mem_dout`).
- Load-use: a load in execute at cycle t appears here in cycle t+1 with `mem_dout` valid; the dependent instruction in execute during t+1 receives the loaded word via `mem_rd_val` — no stall.
- Register file writes at the rising edge ending the cycle `reg_we` is high; value is readable by execute combinationally thereafter.
- Reset (`rst` high at a rising edge): `wb_addr=0`, `wb_data=0`, `pc_out=0`, `inst_out=0`, all counters 0; hence `reg_we=0`, and `mem_rd=0`, `mem_rd_val=0` unless a load is present on inputs. Reset mid-stream discards the WB entry (no write occurs).
- Bubbles injected by execute flush (`inst_in=0`, `rd_in=0`) pass through as no-write, uncounted.

## Structure
- Shared package `sbmips_pkg`: `REG_ZERO=5'd0`, `NOP_INST=32'h00000000`, opcode constants `OP_LW=6'h23`, `OP_SW=6'h2b`.
- No sub-module required; optional `event_counter` (width-parameterised, sync reset, enable) instantiated three times.

## Test plan
- Reset: hold `rst` 2 cycles with `load=1, rd_in=5` -> after reset all counters 0, `reg_we=0`; `mem_rd=5` follows live input.
- ALU write-back: `rd_in=3, rd_val_in=32'h1234` -> next cycle `reg_we=1, reg_waddr=3, reg_wdata=32'h1234`; same cycle `mem_rd=` previous `wb_addr`.
- Load forward: `load=1, rd_in=8, mem_dout=32'hDEADBEEF` -> same cycle `mem_rd=8, mem_rd_val=32'hDEADBEEF`; next cycle write of reg 8 with `32'hDEADBEEF`, `load_cnt=1`.
- Store/r0: `store=1, rd_in=9` -> next cycle `reg_we=0`; `rd_in=0, rd_val_in=5` -> `reg_we=0`, `wb_data=0`.
- Bubble: 4 cycles `inst_in=0` between 3 real instructions -> `retired_cnt=3`.
- Wrap: with `CNT_W=4`, 17 retired instructions -> `retired_cnt=1`.
